hpi_txn_sequencer: RTL
======================

Name: hpi_txn_sequencer

Overview:
- Hardware HPI bus master that sits directly upstream of the HPI I/O pad interface and drives its software-side inputs (address, data_out, r, w, cs).
- Accepts single-word HPI requests: direct register read/write, or two-phase memory read/write (ADDRESS register write followed by DATA register access).
- Generates CY7C67200 HPI strobe timing with programmable setup/strobe/hold widths, and captures read data with the pad interface's 2-cycle round-trip latency compensated.
- Lets fabric logic talk to the USB controller without the soft CPU bit-banging.

Parameters:
- SETUP_CYC, 1, cycles CS low with strobes high before strobe (>=1, <=255)
- STROBE_CYC, 6, cycles RD or WR held low (>=1, <=255)
- HOLD_CYC, 2, cycles CS low after strobe release (>=2, <=255; 2 is the minimum for read capture)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid&&req_ready
- req_op  in  2  00 reg write, 01 reg read, 10 mem write, 11 mem read
- req_reg  in  2  HPI register for reg ops (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS); ignored for mem ops
- req_mem_addr  in  16  controller memory address for mem ops
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes
- rsp_rdata  out  16  read data; holds until the next read completes
- busy  out  1  high whenever state != IDLE
- hpi_address  out  2  to pad interface address input
- hpi_data_out  out  16  to pad interface write-data input
- hpi_data_in  in  16  from pad interface registered read data
- hpi_r  out  1  active-low read strobe
- hpi_w  out  1  active-low write strobe
- hpi_cs  out  1  active-low chip select

Behaviour:
- Reset (async): state IDLE; hpi_r=hpi_w=hpi_cs=1; hpi_address=0; hpi_data_out=0; rsp_valid=0; rsp_rdata=0; busy=0; counters and latched request cleared. Reset asserted mid-transaction deasserts strobes and CS immediately, with no rsp_valid.
- States: IDLE, SETUP, STROBE, HOLD, RECOVER.
- On accept (cycle A), latch op, reg, mem_addr, and wdata.
- Phase selection:
  - mem op: phase=ADDR. Bus address 2, bus data = mem_addr, bus op = write.
  - reg op: phase=FINAL. Bus address = req_reg, bus op from req_op[0].
- Bus values by state:
  - SETUP: hpi_cs=0; address and data driven; strobes 1; lasts SETUP_CYC cycles.
  - STROBE: hpi_cs=0; hpi_w=0 (write) or hpi_r=0 (read); lasts STROBE_CYC cycles.
  - HOLD: hpi_cs=0; strobes 1; address and data held; lasts HOLD_CYC cycles.
  - RECOVER: hpi_cs=1, one cycle.
- Read capture: rsp_rdata <= hpi_data_in on the clock edge ending the 2nd HOLD cycle. This is the pad data sampled during the last pin-level RD-low cycle.
- RECOVER transitions:
  - phase ADDR: set phase=FINAL, load bus address 0 (DATA), data = wdata, op from req_op[0], then go to SETUP.
  - phase FINAL: rsp_valid=1 for this one cycle, then go to IDLE.
- Default timing (1/6/2):
  - Reg op: SETUP A+1; STROBE A+2..A+7; HOLD A+8..A+9; RECOVER A+10 with rsp_valid; req_ready again at A+11.
  - Mem op: rsp_valid at A+20.
- hpi_address and hpi_data_out hold their last values in IDLE. Only strobes and CS return high.
- hpi_r and hpi_w are never both low. CS is low for the full duration of every strobe.
- req_valid while busy is ignored; the request is not latched. Back-to-back requests are accepted at the IDLE cycle following RECOVER.
- Counter is 8 bits and counts down from PARAM-1 in each timed state.

Test Plan:
- Reg write: op=00, reg=1, wdata=16'hBEEF → hpi_cs low A+1..A+9; hpi_w low exactly A+2..A+7; hpi_address=1 and hpi_data_out=BEEF throughout; rsp_valid only at A+10.
- Reg read: op=01, reg=3; pad model returns 16'h1234 two cycles after it sees hpi_r low → rsp_rdata=1234 at A+10; hpi_w never low.
- Mem read: op=11, mem_addr=16'h0500, pad returns 16'h00A5 → phase 1 writes 0500 to address 2; CS high at A+10; phase 2 reads address 0; rsp_valid once at A+20 with rsp_rdata=00A5.
- Back-to-back: req_valid held high with two reg writes → second accepted at A+11; no overlap of CS assertions; exactly two rsp_valid pulses.
- Reset mid-STROBE: assert Reset at A+4 → strobes and CS high in the same cycle (async); state IDLE; no rsp_valid; next request completes normally.
- Param variant SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=4, reg read → strobe low A+3..A+5; capture at the edge ending A+7; rsp_valid at A+10.

Source files
------------

// File: rtl/hpi_txn_sequencer.sv
// hpi_txn_sequencer: fabric-side HPI bus master for the CY7C67200.
// Takes single-word requests and sequences them onto the HPI pad interface
// with programmable setup/strobe/hold widths. Memory operations run as two
// bus cycles: an ADDRESS register write, then a DATA register access.
//
// Request handshake: a request transfers on any clock edge where
// req_valid && req_ready. req_ready is high only in IDLE, so a request
// presented while busy is simply not taken and stays pending upstream.
// Completion is a single-cycle rsp_valid pulse; rsp_rdata holds the most
// recent read result until the next read completes.
module hpi_txn_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_reg,
  input  logic [15:0] req_mem_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_HOLD    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Counter load values: each timed state counts down from width-1 to 0.
  localparam logic [7:0] SETUP_LD    = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD   = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD     = 8'(HOLD_CYC - 1);
  // Counter value during the 2nd HOLD cycle; the pad interface's registered
  // read data for the last RD-low cycle is present exactly then.
  localparam logic [7:0] CAPTURE_CNT = 8'(HOLD_CYC - 2);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [1:0]  r_op;
  logic [1:0]  r_reg;
  logic [15:0] r_mem_addr;
  logic [15:0] r_wdata;
  logic        r_phase_addr;
  logic [15:0] r_rdata;
  logic        w_accept;
  logic        w_bus_rd;
  logic        w_capture;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  // The address phase of a memory op is always a write to ADDRESS.
  assign w_bus_rd  = !r_phase_addr && r_op[0];
  assign w_capture = (r_state == S_HOLD) && (r_cnt == CAPTURE_CNT) && w_bus_rd;

  // Bus address/data come from the latched request, so they hold in IDLE.
  assign hpi_address  = r_phase_addr ? 2'd2 : (r_op[1] ? 2'd0 : r_reg);
  assign hpi_data_out = r_phase_addr ? r_mem_addr : r_wdata;
  assign rsp_rdata    = r_rdata;
  assign dbg_state    = r_state;

  // State and phase counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, counter reload and strobe/CS decode. Strobes and CS are
  // decoded from state so an async reset releases them immediately.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    req_ready    = 1'b0;
    busy         = 1'b1;
    rsp_valid    = 1'b0;
    hpi_cs       = 1'b1;
    hpi_r        = 1'b1;
    hpi_w        = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_state_next = S_SETUP;
          w_cnt_next   = SETUP_LD;
        end
      end
      S_SETUP: begin
        hpi_cs = 1'b0;
        if (r_cnt == 8'd0) begin
          w_state_next = S_STROBE;
          w_cnt_next   = STROBE_LD;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_STROBE: begin
        hpi_cs = 1'b0;
        hpi_r  = !w_bus_rd;
        hpi_w  = w_bus_rd;
        if (r_cnt == 8'd0) begin
          w_state_next = S_HOLD;
          w_cnt_next   = HOLD_LD;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        hpi_cs = 1'b0;
        if (r_cnt == 8'd0) begin
          w_state_next = S_RECOVER;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      S_RECOVER: begin
        if (r_phase_addr) begin
          w_state_next = S_SETUP;
          w_cnt_next   = SETUP_LD;
        end else begin
          rsp_valid    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  // Request latch, memory-op phase tracking and read-data capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op         <= 2'd0;
      r_reg        <= 2'd0;
      r_mem_addr   <= 16'd0;
      r_wdata      <= 16'd0;
      r_phase_addr <= 1'b0;
      r_rdata      <= 16'd0;
    end else begin
      if (w_accept) begin
        r_op         <= req_op;
        r_reg        <= req_reg;
        r_mem_addr   <= req_mem_addr;
        r_wdata      <= req_wdata;
        r_phase_addr <= req_op[1];
      end else if (r_state == S_RECOVER && r_phase_addr) begin
        r_phase_addr <= 1'b0;
      end
      if (w_capture) begin
        r_rdata <= hpi_data_in;
      end
    end
  end

endmodule
